// File: rtl/bpsk_frame_builder_if.sv
// Bundles the payload stream handshake and the frame-RAM write port of bpsk_frame_builder.
// The master modport is the frame builder; the slave modport is the producer/RAM side.
interface bpsk_frame_builder_if;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_last;
   logic        s_ready;
   logic        ram_clk;
   logic        ram_en;
   logic [3:0]  ram_we;
   logic [31:0] ram_addr;
   logic [31:0] ram_wr_data;
   logic        send_signal;
   logic        frame_done;

   modport master (
      input  s_data, s_valid, s_last,
      output s_ready, ram_clk, ram_en, ram_we, ram_addr, ram_wr_data, send_signal, frame_done
   );

   modport slave (
      output s_data, s_valid, s_last,
      input  s_ready, ram_clk, ram_en, ram_we, ram_addr, ram_wr_data, send_signal, frame_done
   );
endinterface

// File: rtl/bpsk_frame_builder.sv
// Assembles sync/header/payload/CRC frames into RAM for a BPSK transmitter and gates send_signal.
// Define FRAME_CRC_EN to compute CRC-32/BZIP2 into the last word; otherwise that word is written as zero.
module bpsk_frame_builder #(
   parameter int          DATA_WIDTH  = 32,
   parameter int          FRAME_WORDS = 38,
   parameter logic [31:0] SYNC_WORD   = 32'h1ACFFC1D,
   parameter logic [7:0]  FRAME_TYPE  = 8'h01
) (
   input logic                  clk,
   input logic                  rst,
   bpsk_frame_builder_if.master bus
);
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SYNC    = 3'd1,
      PAYLOAD = 3'd2,
      PAD     = 3'd3,
      HDR     = 3'd4,
      CRC     = 3'd5,
      DONE    = 3'd6
   } state_t;

   localparam logic [5:0]  LAST_SLOT = 6'(FRAME_WORDS - 4);
   localparam logic [31:0] HDR_ADDR  = 32'd4;
   localparam logic [31:0] PAY_BASE  = 32'd8;
   localparam logic [31:0] CRC_ADDR  = 32'((FRAME_WORDS - 1) * 4);

   state_t                  state_q, state_d;
   logic [5:0]              cnt_q, cnt_d;
   logic [5:0]              n_q, n_d;
   logic [15:0]             seq_q, seq_d;
   logic                    accept_s;
   logic                    wr_en_s;
   logic [31:0]             wr_addr_s;
   logic [DATA_WIDTH-1:0]   wr_data_s;
   logic [DATA_WIDTH-1:0]   crc_word_s;
   logic                    ram_en_q;
   logic [3:0]              ram_we_q;
   logic [31:0]             ram_addr_q;
   logic [DATA_WIDTH-1:0]   ram_wr_data_q;
   logic                    s_ready_q;
   logic                    send_q;
   logic                    done_q;

   assign accept_s = bus.s_valid & s_ready_q;

   // Next-state, counters and the write generated in the current state cycle
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      n_d       = n_q;
      seq_d     = seq_q;
      wr_en_s   = 1'b0;
      wr_addr_s = 32'd0;
      wr_data_s = {DATA_WIDTH{1'b0}};
      case (state_q)
         IDLE: begin
            if (bus.s_valid) begin
               state_d = SYNC;
            end else begin
               state_d = IDLE;
            end
         end
         SYNC: begin
            wr_en_s   = 1'b1;
            wr_addr_s = 32'd0;
            wr_data_s = SYNC_WORD;
            cnt_d     = 6'd0;
            n_d       = 6'd0;
            state_d   = PAYLOAD;
         end
         PAYLOAD: begin
            if (accept_s) begin
               wr_en_s   = 1'b1;
               wr_addr_s = PAY_BASE + {24'd0, cnt_q, 2'b00};
               wr_data_s = bus.s_data;
               cnt_d     = cnt_q + 6'd1;
               n_d       = n_q + 6'd1;
               // A full payload wins over s_last, so s_last on the final slot needs no pad
               if (cnt_q == LAST_SLOT) begin
                  state_d = HDR;
               end else if (bus.s_last) begin
                  state_d = PAD;
               end else begin
                  state_d = PAYLOAD;
               end
            end else begin
               state_d = PAYLOAD;
            end
         end
         PAD: begin
            wr_en_s   = 1'b1;
            wr_addr_s = PAY_BASE + {24'd0, cnt_q, 2'b00};
            wr_data_s = {DATA_WIDTH{1'b0}};
            cnt_d     = cnt_q + 6'd1;
            if (cnt_q == LAST_SLOT) begin
               state_d = HDR;
            end else begin
               state_d = PAD;
            end
         end
         HDR: begin
            wr_en_s   = 1'b1;
            wr_addr_s = HDR_ADDR;
            wr_data_s = {seq_q, 2'b00, n_q, FRAME_TYPE};
            state_d   = CRC;
         end
         CRC: begin
            wr_en_s   = 1'b1;
            wr_addr_s = CRC_ADDR;
            wr_data_s = crc_word_s;
            state_d   = DONE;
         end
         DONE: begin
            seq_d   = seq_q + 16'd1;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and frame bookkeeping registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 6'd0;
         n_q     <= 6'd0;
         seq_q   <= 16'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         n_q     <= n_d;
         seq_q   <= seq_d;
      end
   end

`ifdef FRAME_CRC_EN
   localparam logic [31:0] CRC_POLY = 32'h04C11DB7;
   localparam logic [31:0] CRC_INIT = 32'hFFFFFFFF;

   logic [31:0] crc_q;
   logic        slot_wr_s;

   function automatic logic [31:0] crc32_word(input logic [31:0] crc, input logic [31:0] data);
      logic [31:0] c;
      c = crc;
      for (int i = 31; i >= 0; i--) begin
         if (c[31] ^ data[i]) begin
            c = {c[30:0], 1'b0} ^ CRC_POLY;
         end else begin
            c = {c[30:0], 1'b0};
         end
      end
      return c;
   endfunction

   assign slot_wr_s = (state_q == PAD) | ((state_q == PAYLOAD) & accept_s);

   // CRC accumulates every payload slot, pads included
   always_ff @(posedge clk) begin
      if (rst) begin
         crc_q <= CRC_INIT;
      end else if (state_q == SYNC) begin
         crc_q <= CRC_INIT;
      end else if (slot_wr_s) begin
         crc_q <= crc32_word(crc_q, wr_data_s);
      end else begin
         crc_q <= crc_q;
      end
   end

   assign crc_word_s = ~crc_q;
`else
   assign crc_word_s = 32'h0000_0000;
`endif

   // Output registers: the RAM port lags the generating state by one cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         ram_en_q      <= 1'b0;
         ram_we_q      <= 4'h0;
         ram_addr_q    <= 32'd0;
         ram_wr_data_q <= {DATA_WIDTH{1'b0}};
         s_ready_q     <= 1'b0;
         send_q        <= 1'b0;
         done_q        <= 1'b0;
      end else begin
         ram_en_q  <= wr_en_s;
         ram_we_q  <= wr_en_s ? 4'hF : 4'h0;
         s_ready_q <= (state_d == PAYLOAD);
         done_q    <= (state_d == DONE);
         if (wr_en_s) begin
            ram_addr_q    <= wr_addr_s;
            ram_wr_data_q <= wr_data_s;
         end else begin
            ram_addr_q    <= ram_addr_q;
            ram_wr_data_q <= ram_wr_data_q;
         end
         // Transmitter is held off from SYNC entry until the frame is complete
         if (state_d == SYNC) begin
            send_q <= 1'b0;
         end else if (state_d == DONE) begin
            send_q <= 1'b1;
         end else begin
            send_q <= send_q;
         end
      end
   end

   assign bus.ram_clk     = clk;
   assign bus.ram_en      = ram_en_q;
   assign bus.ram_we      = ram_we_q;
   assign bus.ram_addr    = ram_addr_q;
   assign bus.ram_wr_data = ram_wr_data_q;
   assign bus.s_ready     = s_ready_q;
   assign bus.send_signal = send_q;
   assign bus.frame_done  = done_q;
endmodule
